fb_scanout: RTL

//  Read-side consumer of the 8-bit frame-buffer SDP RAM. On a start pulse, sweeps H_RES x V_RES

---
 rtl/fb_scanout_if.sv | 22 ++
 rtl/fb_scanout.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fb_scanout_if.sv
// Ready/valid pixel stream from the frame-buffer scanout to the display stage.
// Each beat carries start-of-frame, end-of-line and end-of-frame tags.
interface fb_scanout_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  pix_sof;
  logic                  pix_eol;
  logic                  pix_eof;

  modport master (
    output pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
    input  pix_ready
  );

  modport slave (
    input  pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
    output pix_ready
  );
endinterface

// File: rtl/fb_scanout.sv
// Frame-buffer read scanout: sweeps H_RES x V_RES addresses from BASE_ADDR and hides the RAM's
// 1-cycle read latency behind a 2-entry skid FIFO, giving a tagged full-rate ready/valid stream.
module fb_scanout #(
  parameter int unsigned          ADDR_WIDTH = 17,
  parameter int unsigned          DATA_WIDTH = 8,
  parameter int unsigned          H_RES      = 320,
  parameter int unsigned          V_RES      = 240,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  fb_scanout_if.master          pix,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } tag_t;

  typedef struct packed {
    tag_t                  tag;
    logic [DATA_WIDTH-1:0] data;
  } pix_t;

  state_e                state_q;
  logic [XW-1:0]         x_q;
  logic [YW-1:0]         y_q;
  logic [ADDR_WIDTH-1:0] a_q;
  logic                  inf_q;
  tag_t                  inf_tag_q;
  pix_t                  fifo_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            occ_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  last_pix;
  logic [1:0]            occ_d;
  tag_t                  tag_d;
  pix_t                  head;

  // Issue only when the read can always land: FIFO entries plus in-flight read stay within 2.
  always_comb begin
    pop      = (occ_q != 2'd0) && pix.pix_ready;
    push     = inf_q;
    issue    = (state_q == RUN) && ((3'(occ_q) + 3'(inf_q) - 3'(pop)) < 3'd2);
    occ_d    = occ_q + 2'(push) - 2'(pop);
    last_pix = (x_q == XW'(H_RES - 1)) && (y_q == YW'(V_RES - 1));
    tag_d.sof = (x_q == '0) && (y_q == '0);
    tag_d.eol = (x_q == XW'(H_RES - 1));
    tag_d.eof = last_pix;
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      a_q       <= BASE_ADDR;
      inf_q     <= 1'b0;
      inf_tag_q <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      occ_q  <= occ_d;
      inf_q  <= issue;
      if (issue) begin
        inf_tag_q <= tag_d;
      end
      // RAM data returns the cycle after issue; pair it with the tags captured at issue.
      if (push) begin
        fifo_q[wr_ptr_q] <= '{tag: inf_tag_q, data: ram_rd_data};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
            a_q     <= BASE_ADDR;
          end
        end
        RUN: begin
          if (issue) begin
            a_q <= a_q + ADDR_WIDTH'(1);
            if (x_q == XW'(H_RES - 1)) begin
              x_q <= '0;
              y_q <= y_q + YW'(1);
            end else begin
              x_q <= x_q + XW'(1);
            end
            if (last_pix) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Nothing issues here, so an empty FIFO next cycle means the last pixel just left.
          if (occ_d == 2'd0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign head          = fifo_q[rd_ptr_q];
  assign pix.pix_data  = head.data;
  assign pix.pix_sof   = head.tag.sof;
  assign pix.pix_eol   = head.tag.eol;
  assign pix.pix_eof   = head.tag.eof;
  assign pix.pix_valid = (occ_q != 2'd0);

  assign ram_rd_addr = a_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;

endmodule
